// File: rtl/dsp_bank2_arbiter.sv
// Bank-2 arbiter: a sample FIFO drains into a circular region of single-ported bank 2.
// Core accesses to bank 2 compete with those writes under bounded starvation; bank 1 reads pass through.
module dsp_bank2_arbiter #(
    parameter int ADDR_LEN   = 15,
    parameter int WORD_LEN   = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                core_req_i,
    input  logic                core_we_i,
    input  logic [15:0]         core_addr_i,
    input  logic [WORD_LEN-1:0] core_wdata_i,
    output logic                core_stall_o,
    output logic                core_ack_o,
    output logic [WORD_LEN-1:0] core_rdata_o,
    input  logic                smp_valid_i,
    input  logic [WORD_LEN-1:0] smp_data_i,
    output logic                smp_ready_o,
    input  logic                cfg_load_i,
    input  logic [ADDR_LEN-1:0] ring_base_i,
    input  logic [ADDR_LEN-1:0] ring_len_i,
    output logic [ADDR_LEN-1:0] wr_ptr_o,
    output logic                wrap_pulse_o,
    output logic [ADDR_LEN-1:0] b1_addr_o,
    input  logic [WORD_LEN-1:0] b1_rdata_i,
    output logic [ADDR_LEN-1:0] b2_addr_o,
    output logic [WORD_LEN-1:0] b2_wdata_o,
    output logic                b2_we_o,
    input  logic [WORD_LEN-1:0] b2_rdata_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    logic [WORD_LEN-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [SC_W-1:0]     starve_q, starve_d;
    logic [ADDR_LEN-1:0] wr_ptr_q, wr_ptr_d, ring_base_q, ring_base_d, ring_len_q, ring_len_d;
    logic                ack_q, ack_d, bank_sel_q, bank_sel_d, wrap_q, wrap_d;

    logic                fifo_empty, fifo_full, push, core_b2_req;
    logic                smp_grant, core_b2_grant, core_grant;
    logic [ADDR_LEN-1:0] ring_end;

    assign fifo_empty    = (count_q == '0);
    assign fifo_full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign smp_ready_o   = !fifo_full && (ring_len_q != '0);
    assign push          = smp_valid_i && smp_ready_o;
    assign core_b2_req   = core_req_i && core_addr_i[15];

    // The sample path only yields to the core while it is neither starved nor backed up.
    assign smp_grant     = !fifo_empty &&
                           (!core_b2_req || (starve_q == SC_W'(STARVE_MAX)) || fifo_full);
    assign core_b2_grant = core_b2_req && !smp_grant;
    assign core_grant    = (core_req_i && !core_addr_i[15]) || core_b2_grant;
    assign core_stall_o  = core_b2_req && !core_b2_grant;

    assign ring_end      = ring_base_q + ring_len_q - ADDR_LEN'(1);
    assign b1_addr_o     = core_addr_i[ADDR_LEN-1:0];
    assign core_ack_o    = ack_q;
    assign core_rdata_o  = bank_sel_q ? b2_rdata_i : b1_rdata_i;
    assign wr_ptr_o      = wr_ptr_q;
    assign wrap_pulse_o  = wrap_q;

    always_comb begin
        b2_addr_o  = core_addr_i[ADDR_LEN-1:0];
        b2_wdata_o = core_wdata_i;
        b2_we_o    = 1'b0;
        if (smp_grant) begin
            b2_addr_o  = wr_ptr_q;
            b2_wdata_o = fifo_mem_q[rd_idx_q];
            b2_we_o    = 1'b1;
        end else if (core_b2_grant) begin
            b2_we_o    = core_we_i;
        end
    end

    always_comb begin
        rd_idx_d    = rd_idx_q;
        wr_idx_d    = wr_idx_q;
        count_d     = count_q;
        starve_d    = starve_q;
        wr_ptr_d    = wr_ptr_q;
        ring_base_d = ring_base_q;
        ring_len_d  = ring_len_q;
        ack_d       = core_grant;
        bank_sel_d  = core_addr_i[15];
        wrap_d      = 1'b0;

        if (push) wr_idx_d = wr_idx_q + PTR_W'(1);
        if (smp_grant) rd_idx_d = rd_idx_q + PTR_W'(1);
        if (push && !smp_grant) count_d = count_q + CNT_W'(1);
        else if (!push && smp_grant) count_d = count_q - CNT_W'(1);

        if (fifo_empty || smp_grant) starve_d = '0;
        else if (core_b2_grant && (starve_q != SC_W'(STARVE_MAX))) starve_d = starve_q + SC_W'(1);

        if (smp_grant) begin
            if (wr_ptr_q == ring_end) begin
                wr_ptr_d = ring_base_q;
                wrap_d   = !cfg_load_i;
            end else begin
                wr_ptr_d = wr_ptr_q + ADDR_LEN'(1);
            end
        end

        // A reconfiguration overrides the pointer advance but not the write already on the bus.
        if (cfg_load_i) begin
            ring_base_d = ring_base_i;
            ring_len_d  = ring_len_i;
            wr_ptr_d    = ring_base_i;
            count_d     = '0;
            rd_idx_d    = '0;
            wr_idx_d    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_idx_q    <= '0;
            wr_idx_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            wr_ptr_q    <= '0;
            ring_base_q <= '0;
            ring_len_q  <= '0;
            ack_q       <= 1'b0;
            bank_sel_q  <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            rd_idx_q    <= rd_idx_d;
            wr_idx_q    <= wr_idx_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            wr_ptr_q    <= wr_ptr_d;
            ring_base_q <= ring_base_d;
            ring_len_q  <= ring_len_d;
            ack_q       <= ack_d;
            bank_sel_q  <= bank_sel_d;
            wrap_q      <= wrap_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem_q[wr_idx_q] <= smp_data_i;
    end

endmodule

// File: tb/tb_dsp_bank2_arbiter.sv
// Directed vector bench for dsp_bank2_arbiter: one table row per clock cycle,
// with hand-computed outputs expected during that cycle.
module tb_dsp_bank2_arbiter;

    logic        clk = 1'b0;
    logic        rst, coreReq, coreWe, smpValid, cfgLoad;
    logic [15:0] coreAddr, coreWdata, smpData;
    logic [14:0] ringBase, ringLen;
    logic        coreStall, coreAck, smpReady, wrapPulse, b2We;
    logic [15:0] coreRdata, b2Wdata;
    logic [15:0] b1Rdata = 16'h0000;
    logic [15:0] b2Rdata = 16'h0000;
    logic [14:0] wrPtr, b1Addr, b2Addr;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    dsp_bank2_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .core_req_i(coreReq), .core_we_i(coreWe), .core_addr_i(coreAddr), .core_wdata_i(coreWdata),
        .core_stall_o(coreStall), .core_ack_o(coreAck), .core_rdata_o(coreRdata),
        .smp_valid_i(smpValid), .smp_data_i(smpData), .smp_ready_o(smpReady),
        .cfg_load_i(cfgLoad), .ring_base_i(ringBase), .ring_len_i(ringLen),
        .wr_ptr_o(wrPtr), .wrap_pulse_o(wrapPulse),
        .b1_addr_o(b1Addr), .b1_rdata_i(b1Rdata),
        .b2_addr_o(b2Addr), .b2_wdata_o(b2Wdata), .b2_we_o(b2We), .b2_rdata_i(b2Rdata)
    );

    // SRAM stand-ins: read data is a fixed tag of the address sampled on the previous edge.
    always @(posedge clk) begin
        b1Rdata <= {1'b1, b1Addr};
        b2Rdata <= {1'b0, b2Addr} | 16'h4000;
    end

    typedef struct {
        logic        rst, req, we;
        logic [15:0] addr, wdata;
        logic        sv;
        logic [15:0] sd;
        logic        cfg;
        logic [14:0] base, len;
        logic        eStall, eAck;
        logic [15:0] eRdata;
        logic        eWe, eAddrChk;
        logic [14:0] eAddr;
        logic [15:0] eData;
        logic        eReady;
        logic [14:0] ePtr;
        logic        eWrap;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, q, w, input logic [15:0] a, wd, input logic sv, input logic [15:0] sd,
        input logic cfg, input logic [14:0] base, len,
        input logic st, ak, input logic [15:0] rd, input logic we, ac, input logic [14:0] ea,
        input logic [15:0] ed, input logic rdy, input logic [14:0] ptr, input logic wp);
        vec_t v;
        v.rst = r; v.req = q; v.we = w; v.addr = a; v.wdata = wd; v.sv = sv; v.sd = sd;
        v.cfg = cfg; v.base = base; v.len = len;
        v.eStall = st; v.eAck = ak; v.eRdata = rd; v.eWe = we; v.eAddrChk = ac; v.eAddr = ea;
        v.eData = ed; v.eReady = rdy; v.ePtr = ptr; v.eWrap = wp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst = v.rst; coreReq = v.req; coreWe = v.we; coreAddr = v.addr; coreWdata = v.wdata;
        smpValid = v.sv; smpData = v.sd; cfgLoad = v.cfg; ringBase = v.base; ringLen = v.len;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        check($sformatf("row%0d.stall", idx), 32'(coreStall), 32'(v.eStall));
        check($sformatf("row%0d.ack", idx), 32'(coreAck), 32'(v.eAck));
        if (v.eAck) check($sformatf("row%0d.rdata", idx), 32'(coreRdata), 32'(v.eRdata));
        check($sformatf("row%0d.b2we", idx), 32'(b2We), 32'(v.eWe));
        if (v.eAddrChk) check($sformatf("row%0d.b2addr", idx), 32'(b2Addr), 32'(v.eAddr));
        if (v.eWe) check($sformatf("row%0d.b2wdata", idx), 32'(b2Wdata), 32'(v.eData));
        check($sformatf("row%0d.ready", idx), 32'(smpReady), 32'(v.eReady));
        check($sformatf("row%0d.wrptr", idx), 32'(wrPtr), 32'(v.ePtr));
        check($sformatf("row%0d.wrap", idx), 32'(wrapPulse), 32'(v.eWrap));
    endtask

    initial begin
        // Reset, zero-length ring, then ring 0x100/4 with six samples and no core traffic.
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,0,16'h0000,0,15'h000,15'h0, 0,0,16'h0, 0,0,15'h000,16'h0000, 0,15'h000,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,1,16'h0011,0,15'h000,15'h0, 0,0,16'h0, 0,0,15'h000,16'h0000, 0,15'h000,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,0,16'h0000,1,15'h100,15'h4, 0,0,16'h0, 0,0,15'h000,16'h0000, 0,15'h000,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,1,16'h00A0,0,15'h000,15'h0, 0,0,16'h0, 0,0,15'h000,16'h0000, 1,15'h100,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,1,16'h00A1,0,15'h000,15'h0, 0,0,16'h0, 1,1,15'h100,16'h00A0, 1,15'h100,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,1,16'h00A2,0,15'h000,15'h0, 0,0,16'h0, 1,1,15'h101,16'h00A1, 1,15'h101,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,1,16'h00A3,0,15'h000,15'h0, 0,0,16'h0, 1,1,15'h102,16'h00A2, 1,15'h102,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,1,16'h00A4,0,15'h000,15'h0, 0,0,16'h0, 1,1,15'h103,16'h00A3, 1,15'h103,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,1,16'h00A5,0,15'h000,15'h0, 0,0,16'h0, 1,1,15'h100,16'h00A4, 1,15'h100,1));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,0,16'h0000,0,15'h000,15'h0, 0,0,16'h0, 1,1,15'h101,16'h00A5, 1,15'h101,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,0,16'h0000,0,15'h000,15'h0, 0,0,16'h0, 0,0,15'h000,16'h0000, 1,15'h102,0));
        // Bank 1 load and store alongside samples: never stalled, acked next cycle.
        vecs.push_back(mk(0,1,0,16'h0010,16'h0000,1,16'h00B0,0,15'h000,15'h0, 0,0,16'h0, 0,0,15'h000,16'h0000, 1,15'h102,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,1,16'h00B1,0,15'h000,15'h0, 0,1,16'h8010, 1,1,15'h102,16'h00B0, 1,15'h102,0));
        vecs.push_back(mk(0,1,1,16'h0020,16'hDEAD,0,16'h0000,0,15'h000,15'h0, 0,0,16'h0, 1,1,15'h103,16'h00B1, 1,15'h103,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,0,16'h0000,0,15'h000,15'h0, 0,1,16'h8020, 0,0,15'h000,16'h0000, 1,15'h100,1));
        // Bank 2 store with an empty FIFO.
        vecs.push_back(mk(0,1,1,16'h8005,16'hBEEF,0,16'h0000,0,15'h000,15'h0, 0,0,16'h0, 1,1,15'h005,16'hBEEF, 1,15'h100,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,0,16'h0000,0,15'h000,15'h0, 0,1,16'h4005, 0,0,15'h000,16'h0000, 1,15'h100,0));
        // Bank 2 loads every cycle, one sample per 4 cycles: the sample wins every 4th cycle.
        vecs.push_back(mk(0,1,0,16'h8007,16'h0000,1,16'h00C0,0,15'h000,15'h0, 0,0,16'h0, 0,1,15'h007,16'h0000, 1,15'h100,0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0,1,0,16'h8007,16'h0000,0,16'h0000,0,15'h000,15'h0, 0,1,16'h4007, 0,1,15'h007,16'h0000, 1,15'h100,0));
        vecs.push_back(mk(0,1,0,16'h8007,16'h0000,1,16'h00C1,0,15'h000,15'h0, 1,1,16'h4007, 1,1,15'h100,16'h00C0, 1,15'h100,0));
        vecs.push_back(mk(0,1,0,16'h8007,16'h0000,0,16'h0000,0,15'h000,15'h0, 0,0,16'h0, 0,1,15'h007,16'h0000, 1,15'h101,0));
        for (int k = 0; k < 2; k++)
            vecs.push_back(mk(0,1,0,16'h8007,16'h0000,0,16'h0000,0,15'h000,15'h0, 0,1,16'h4007, 0,1,15'h007,16'h0000, 1,15'h101,0));
        vecs.push_back(mk(0,1,0,16'h8007,16'h0000,0,16'h0000,0,15'h000,15'h0, 1,1,16'h4007, 1,1,15'h101,16'h00C1, 1,15'h101,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,0,16'h0000,0,15'h000,15'h0, 0,0,16'h0, 0,0,15'h000,16'h0000, 1,15'h102,0));
        // Fill the FIFO under a held bank 2 request; the full FIFO takes the bank and stalls the core.
        vecs.push_back(mk(0,1,0,16'h8009,16'h0000,1,16'h00D0,0,15'h000,15'h0, 0,0,16'h0, 0,1,15'h009,16'h0000, 1,15'h102,0));
        vecs.push_back(mk(0,1,0,16'h8009,16'h0000,1,16'h00D1,0,15'h000,15'h0, 0,1,16'h4009, 0,1,15'h009,16'h0000, 1,15'h102,0));
        vecs.push_back(mk(0,1,0,16'h8009,16'h0000,1,16'h00D2,0,15'h000,15'h0, 0,1,16'h4009, 0,1,15'h009,16'h0000, 1,15'h102,0));
        vecs.push_back(mk(0,1,0,16'h8009,16'h0000,1,16'h00D3,0,15'h000,15'h0, 0,1,16'h4009, 0,1,15'h009,16'h0000, 1,15'h102,0));
        vecs.push_back(mk(0,1,0,16'h8009,16'h0000,1,16'h00D4,0,15'h000,15'h0, 1,1,16'h4009, 1,1,15'h102,16'h00D0, 0,15'h102,0));
        vecs.push_back(mk(0,1,0,16'h8009,16'h0000,0,16'h0000,0,15'h000,15'h0, 0,0,16'h0, 0,1,15'h009,16'h0000, 1,15'h103,0));
        // Reset with three samples queued and a core ack pending.
        vecs.push_back(mk(1,0,0,16'h0000,16'h0000,0,16'h0000,0,15'h000,15'h0, 0,1,16'h4009, 1,1,15'h103,16'h00D1, 1,15'h103,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,0,16'h0000,0,15'h000,15'h0, 0,0,16'h0, 0,0,15'h000,16'h0000, 0,15'h000,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,1,16'h0055,0,15'h000,15'h0, 0,0,16'h0, 0,0,15'h000,16'h0000, 0,15'h000,0));
        // Reconfigure during a sample write: the write lands at the old pointer, the FIFO is flushed.
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,0,16'h0000,1,15'h200,15'h4, 0,0,16'h0, 0,0,15'h000,16'h0000, 0,15'h000,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,1,16'h00E0,0,15'h000,15'h0, 0,0,16'h0, 0,0,15'h000,16'h0000, 1,15'h200,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,1,16'h00E1,0,15'h000,15'h0, 0,0,16'h0, 1,1,15'h200,16'h00E0, 1,15'h200,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,1,16'h00E2,1,15'h300,15'h4, 0,0,16'h0, 1,1,15'h201,16'h00E1, 1,15'h201,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,0,16'h0000,0,15'h000,15'h0, 0,0,16'h0, 0,0,15'h000,16'h0000, 1,15'h300,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,1,16'h00E3,0,15'h000,15'h0, 0,0,16'h0, 0,0,15'h000,16'h0000, 1,15'h300,0));
        vecs.push_back(mk(0,0,0,16'h0000,16'h0000,0,16'h0000,0,15'h000,15'h0, 0,0,16'h0, 1,1,15'h300,16'h00E3, 1,15'h300,0));

        applyStimulus(mk(1,0,0,16'h0000,16'h0000,0,16'h0000,0,15'h000,15'h0, 0,0,16'h0, 0,0,15'h000,16'h0000, 0,15'h000,0));
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i], i);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
